hssi_tc_mailbox_ctrl: RTL and testbench

Mailbox controller between the AFU CSR window (mailbox at 0x40030) and the HSSI traffic-controller register space (TG 0x00-0xF4, TM 0x100-0x10C, loopback 0x200).
- Host software posts an indirect address, write data and a command (RD or WR).
- The block runs one indirect access to the selected Ethernet port's traffic controller, with handshake and timeout.
- It reports completion and read data back through the mailbox registers.

---
 rtl/hssi_tc_mailbox_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_hssi_tc_mailbox_ctrl.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hssi_tc_mailbox_ctrl.sv
// hssi_tc_mailbox_ctrl: host CSR mailbox that runs one indirect
// read or write to a HSSI traffic controller, with ack timeout.
module hssi_tc_mailbox_ctrl #(
  parameter  int TC_ADDR_W   = 16,
  parameter  int DATA_W      = 32,
  parameter  int NUM_PORTS   = 4,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int PORT_W      = (NUM_PORTS > 1) ?
                               $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 csr_wr,
  input  logic                 csr_rd,
  input  logic [3:0]           csr_addr,
  input  logic [DATA_W-1:0]    csr_wdata,
  output logic [DATA_W-1:0]    csr_rdata,
  output logic                 csr_rdata_vld,
  input  logic [PORT_W-1:0]    port_sel,
  output logic                 tc_req,
  output logic                 tc_wr,
  output logic [PORT_W-1:0]    tc_port,
  output logic [TC_ADDR_W-1:0] tc_addr,
  output logic [DATA_W-1:0]    tc_wdata,
  input  logic                 tc_ack,
  input  logic [DATA_W-1:0]    tc_rdata,
  output logic                 busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [3:0] OFS_CMD = 4'h0;
  localparam logic [3:0] OFS_ADR = 4'h4;
  localparam logic [3:0] OFS_RDD = 4'h8;
  localparam logic [3:0] OFS_WRD = 4'hC;

  localparam logic [1:0] CMD_NOOP = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wrd_q;
  logic [DATA_W-1:0] rdd_q;
  logic              ack_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic sel_cmd;
  logic sel_adr;
  logic sel_rdd;
  logic sel_wrd;
  logic wr_ok;
  logic cmd_wr;
  logic go_rd;
  logic go_wr;
  logic go;
  logic noop;
  logic in_issue;
  logic done;
  logic expire;

  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_mux;

  assign sel_cmd = (csr_addr == OFS_CMD);
  assign sel_adr = (csr_addr == OFS_ADR);
  assign sel_rdd = (csr_addr == OFS_RDD);
  assign sel_wrd = (csr_addr == OFS_WRD);

  // Host writes are only accepted while no access is in flight.
  assign in_issue = (state_q == ISSUE);
  assign wr_ok    = csr_wr & ~in_issue;
  assign cmd_wr   = wr_ok & sel_cmd;
  assign go_rd    = cmd_wr & (csr_wdata[1:0] == CMD_RD);
  assign go_wr    = cmd_wr & (csr_wdata[1:0] == CMD_WR);
  assign go       = go_rd | go_wr;
  assign noop     = cmd_wr & (csr_wdata[1:0] == CMD_NOOP);

  // A late ack on the last counted cycle still wins.
  assign done   = in_issue & tc_ack;
  assign expire = in_issue & ~tc_ack & (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (done || expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tc_req = 1'b0;
    busy   = 1'b0;
    if (state_q == ISSUE) begin
      tc_req = 1'b1;
      busy   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wrd_q  <= '0;
    end else begin
      if (wr_ok && sel_adr) begin
        addr_q <= csr_wdata;
      end
      if (wr_ok && sel_wrd) begin
        wrd_q <= csr_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_addr  <= '0;
      tc_wdata <= '0;
      tc_port  <= '0;
      tc_wr    <= 1'b0;
    end else if (go) begin
      tc_addr  <= addr_q[TC_ADDR_W-1:0];
      tc_wdata <= wrd_q;
      tc_port  <= port_sel;
      tc_wr    <= go_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (go) begin
      cnt_q <= '0;
    end else if (in_issue && !tc_ack && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rdd_q <= '0;
    end else begin
      unique case (1'b1)
        go || noop: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
        end
        done: begin
          ack_q <= 1'b1;
          if (!tc_wr) begin
            rdd_q <= tc_rdata;
          end
        end
        expire: begin
          ack_q <= 1'b1;
          err_q <= 1'b1;
          rdd_q <= '1;
        end
        default: ;
      endcase
    end
  end

  assign status = {{(DATA_W-4){1'b0}}, err_q, ack_q,
                   in_issue & tc_wr, in_issue & ~tc_wr};

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_cmd: rd_mux = status;
      sel_adr: rd_mux = addr_q;
      sel_rdd: rd_mux = rdd_q;
      sel_wrd: rd_mux = wrd_q;
      default: rd_mux = '0;
    endcase
  end

  // Reads see the pre-write value of a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata     <= '0;
      csr_rdata_vld <= 1'b0;
    end else begin
      csr_rdata_vld <= csr_rd;
      if (csr_rd) begin
        csr_rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_hssi_tc_mailbox_ctrl.sv
// tb_hssi_tc_mailbox_ctrl: directed bench for the HSSI TC
// mailbox controller, TIMEOUT_CYC reduced to 16.
module tb_hssi_tc_mailbox_ctrl;

  localparam int TC_ADDR_W   = 16;
  localparam int DATA_W      = 32;
  localparam int NUM_PORTS   = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int PORT_W      = 2;

  localparam logic [3:0] A_CMD = 4'h0;
  localparam logic [3:0] A_ADR = 4'h4;
  localparam logic [3:0] A_RDD = 4'h8;
  localparam logic [3:0] A_WRD = 4'hC;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 csr_wr;
  logic                 csr_rd;
  logic [3:0]           csr_addr;
  logic [DATA_W-1:0]    csr_wdata;
  logic [DATA_W-1:0]    csr_rdata;
  logic                 csr_rdata_vld;
  logic [PORT_W-1:0]    port_sel;
  logic                 tc_req;
  logic                 tc_wr;
  logic [PORT_W-1:0]    tc_port;
  logic [TC_ADDR_W-1:0] tc_addr;
  logic [DATA_W-1:0]    tc_wdata;
  logic                 tc_ack;
  logic [DATA_W-1:0]    tc_rdata;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] rd_d;
  logic              rd_v;

  hssi_tc_mailbox_ctrl #(
    .TC_ADDR_W  (TC_ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_PORTS  (NUM_PORTS),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_wr       (csr_wr),
    .csr_rd       (csr_rd),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .csr_rdata_vld(csr_rdata_vld),
    .port_sel     (port_sel),
    .tc_req       (tc_req),
    .tc_wr        (tc_wr),
    .tc_port      (tc_port),
    .tc_addr      (tc_addr),
    .tc_wdata     (tc_wdata),
    .tc_ack       (tc_ack),
    .tc_rdata     (tc_rdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Tasks are entered and left on a falling edge.
  task automatic csr_write(input logic [3:0] a,
                           input logic [31:0] d);
    csr_wr    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    @(negedge clk);
    csr_wr = 1'b0;
  endtask

  task automatic csr_read(input  logic [3:0]  a,
                          output logic [31:0] d,
                          output logic        v);
    csr_rd   = 1'b1;
    csr_addr = a;
    @(negedge clk);
    csr_rd = 1'b0;
    d = csr_rdata;
    v = csr_rdata_vld;
  endtask

  task automatic test_reset;
    logic [31:0] zv;
    rst_n     = 1'b0;
    csr_wr    = 1'b0;
    csr_rd    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    port_sel  = '0;
    tc_ack    = 1'b0;
    tc_rdata  = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tc_req, busy, csr_rdata_vld, tc_wr, tc_port,
         tc_addr, tc_wdata, csr_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: req=%b busy=%b vld=%b want 0",
               tc_req, busy, csr_rdata_vld);
    end
    rst_n = 1'b1;
    @(negedge clk);
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if ({rd_v, rd_d} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_cmd: got vld=%b %h want vld=1 0",
               rd_v, rd_d);
    end
    for (int i = 1; i < 4; i++) begin
      zv = 32'h0;
      csr_read(4'(i * 4), rd_d, rd_v);
      n_checks++;
      if (rd_d !== zv) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h want %h",
                 i * 4, rd_d, zv);
      end
    end
  endtask

  task automatic test_read;
    csr_write(A_ADR, 32'h100);
    port_sel = 2'd2;
    csr_write(A_CMD, 32'h1);
    n_checks++;
    if ({tc_req, busy, tc_wr, tc_port, tc_addr} !==
        {1'b1, 1'b1, 1'b0, 2'd2, 16'h0100}) begin
      n_fail++;
      $display("FAIL rd_issue: req=%b busy=%b wr=%b port=%0d addr=%h want 1 1 0 2 0100",
               tc_req, busy, tc_wr, tc_port, tc_addr);
    end
    repeat (3) @(negedge clk);
    tc_ack   = 1'b1;
    tc_rdata = 32'h0000_0040;
    @(negedge clk);
    tc_ack   = 1'b0;
    tc_rdata = '0;
    n_checks++;
    if ({tc_req, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_done: req=%b busy=%b want 0 0",
               tc_req, busy);
    end
    csr_read(A_RDD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h40) begin
      n_fail++;
      $display("FAIL rd_rddata: got %h want 00000040", rd_d);
    end
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h4) begin
      n_fail++;
      $display("FAIL rd_cmd: got %h want 00000004", rd_d);
    end
  endtask

  task automatic test_write;
    csr_write(A_ADR, 32'h03);
    csr_write(A_WRD, 32'h1);
    csr_write(A_CMD, 32'h2);
    n_checks++;
    if ({tc_req, tc_wr, tc_wdata, tc_addr} !==
        {1'b1, 1'b1, 32'h1, 16'h0003}) begin
      n_fail++;
      $display("FAIL wr_issue: req=%b wr=%b wdata=%h addr=%h want 1 1 00000001 0003",
               tc_req, tc_wr, tc_wdata, tc_addr);
    end
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h2) begin
      n_fail++;
      $display("FAIL wr_inflight: got %h want 00000002", rd_d);
    end
    tc_ack   = 1'b1;
    tc_rdata = 32'h5555_5555;
    @(negedge clk);
    tc_ack   = 1'b0;
    tc_rdata = '0;
    n_checks++;
    if ({tc_req, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_drop: req=%b busy=%b want 0 0",
               tc_req, busy);
    end
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h4) begin
      n_fail++;
      $display("FAIL wr_cmd: got %h want 00000004", rd_d);
    end
    csr_read(A_RDD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h40) begin
      n_fail++;
      $display("FAIL wr_rddata_kept: got %h want 00000040",
               rd_d);
    end
  endtask

  task automatic test_timeout;
    int n;
    port_sel = 2'd0;
    csr_write(A_CMD, 32'h1);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (!tc_req) break;
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL to_req_len: got %0d want 16", n);
    end
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'hC) begin
      n_fail++;
      $display("FAIL to_cmd: got %h want 0000000c", rd_d);
    end
    csr_write(A_RDD, 32'h1234);
    csr_read(A_RDD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL to_rddata: got %h want ffffffff", rd_d);
    end
    csr_write(A_CMD, 32'h0);
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h0) begin
      n_fail++;
      $display("FAIL to_noop: got %h want 00000000", rd_d);
    end
    csr_write(A_CMD, 32'h3);
    n_checks++;
    if ({tc_req, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL cmd3_ignored: req=%b busy=%b want 0 0",
               tc_req, busy);
    end
  endtask

  task automatic test_busy_writes;
    int extra;
    csr_write(A_ADR, 32'h5A5A_0010);
    port_sel = 2'd1;
    csr_write(A_CMD, 32'h1);
    csr_write(A_ADR, 32'h200);
    csr_write(A_CMD, 32'h2);
    port_sel = 2'd3;
    @(negedge clk);
    n_checks++;
    if ({tc_req, tc_wr, tc_port, tc_addr} !==
        {1'b1, 1'b0, 2'd1, 16'h0010}) begin
      n_fail++;
      $display("FAIL busy_latched: req=%b wr=%b port=%0d addr=%h want 1 0 1 0010",
               tc_req, tc_wr, tc_port, tc_addr);
    end
    tc_ack   = 1'b1;
    tc_rdata = 32'h0000_0BEE;
    @(negedge clk);
    tc_ack   = 1'b0;
    tc_rdata = '0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (tc_req) extra++;
      @(negedge clk);
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL busy_one_pulse: got %0d extra req cycles want 0",
               extra);
    end
    csr_read(A_ADR, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h5A5A_0010) begin
      n_fail++;
      $display("FAIL busy_addr_kept: got %h want 5a5a0010",
               rd_d);
    end
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h4) begin
      n_fail++;
      $display("FAIL busy_cmd: got %h want 00000004", rd_d);
    end
  endtask

  task automatic test_ack_at_timeout;
    csr_write(A_CMD, 32'h1);
    repeat (15) @(negedge clk);
    n_checks++;
    if (tc_req !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_req_held: got %b want 1", tc_req);
    end
    tc_ack   = 1'b1;
    tc_rdata = 32'hA5A5_1234;
    @(negedge clk);
    tc_ack   = 1'b0;
    tc_rdata = '0;
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h4) begin
      n_fail++;
      $display("FAIL edge_cmd: got %h want 00000004", rd_d);
    end
    csr_read(A_RDD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'hA5A5_1234) begin
      n_fail++;
      $display("FAIL edge_rddata: got %h want a5a51234", rd_d);
    end
    for (int i = 0; i < 3; i++) begin
      tc_ack   = 1'b1;
      tc_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      tc_ack   = 1'b0;
      @(negedge clk);
    end
    tc_rdata = '0;
    csr_read(A_RDD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'hA5A5_1234) begin
      n_fail++;
      $display("FAIL stray_rddata: got %h want a5a51234", rd_d);
    end
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if ({busy, rd_d} !== {1'b0, 32'h4}) begin
      n_fail++;
      $display("FAIL stray_cmd: busy=%b cmd=%h want 0 00000004",
               busy, rd_d);
    end
  endtask

  task automatic test_reset_mid;
    csr_write(A_CMD, 32'h1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tc_req, busy, csr_rdata_vld} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_outs: req=%b busy=%b vld=%b want 0 0 0",
               tc_req, busy, csr_rdata_vld);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_cmd: got %h want 00000000", rd_d);
    end
    csr_read(A_ADR, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_addr: got %h want 00000000", rd_d);
    end
    csr_write(A_ADR, 32'h104);
    csr_write(A_CMD, 32'h1);
    tc_ack   = 1'b1;
    tc_rdata = 32'h77;
    @(negedge clk);
    tc_ack   = 1'b0;
    tc_rdata = '0;
    n_checks++;
    if ({tc_req, busy, tc_addr} !== {2'b00, 16'h0104}) begin
      n_fail++;
      $display("FAIL rst_new_done: req=%b busy=%b addr=%h want 0 0 0104",
               tc_req, busy, tc_addr);
    end
    csr_read(A_CMD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h4) begin
      n_fail++;
      $display("FAIL rst_new_cmd: got %h want 00000004", rd_d);
    end
    csr_read(A_RDD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h77) begin
      n_fail++;
      $display("FAIL rst_new_rddata: got %h want 00000077", rd_d);
    end
  endtask

  task automatic test_simul_rw;
    csr_wr    = 1'b1;
    csr_rd    = 1'b1;
    csr_addr  = A_WRD;
    csr_wdata = 32'h99;
    @(negedge clk);
    csr_wr = 1'b0;
    csr_rd = 1'b0;
    n_checks++;
    if ({csr_rdata_vld, csr_rdata} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL simul_old: vld=%b got %h want 1 00000000",
               csr_rdata_vld, csr_rdata);
    end
    csr_read(A_WRD, rd_d, rd_v);
    n_checks++;
    if (rd_d !== 32'h99) begin
      n_fail++;
      $display("FAIL simul_new: got %h want 00000099", rd_d);
    end
    @(negedge clk);
    n_checks++;
    if ({csr_rdata_vld, csr_rdata} !== {1'b0, 32'h99}) begin
      n_fail++;
      $display("FAIL rdata_hold: vld=%b got %h want 0 00000099",
               csr_rdata_vld, csr_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_busy_writes();
    test_ack_at_timeout();
    test_reset_mid();
    test_simul_rw();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
